// File: rtl/gen_led_signal_if.sv
// Request/indicator bundle for gen_led_signal: burst request in, indicator and
// burst status out.
interface gen_led_signal_if #(
    parameter int CNT_WIDTH = 4
) ();
    logic                 pulse_in;
    logic [CNT_WIDTH-1:0] blink_cnt;
    logic                 led_out_n;
    logic                 busy;
    logic                 done;

    modport master (
        output pulse_in, blink_cnt,
        input  led_out_n, busy, done
    );

    modport slave (
        input  pulse_in, blink_cnt,
        output led_out_n, busy, done
    );
endinterface

// File: rtl/gen_led_signal.sv
// Pulse-to-indicator driver: turns a one-cycle request into N active-low blinks
// of programmable on/off length, with a one-deep queue for a follow-up burst.
module gen_led_signal #(
    parameter int CTR_WIDTH  = 22,
    parameter int ON_CYCLES  = 2500000,
    parameter int OFF_CYCLES = 2500000,
    parameter int CNT_WIDTH  = 4
) (
    input  logic             clk,
    input  logic             rst,
    gen_led_signal_if.slave  io
);
    typedef enum logic [1:0] {IDLE, ON, OFF, GAP} state_t;

    localparam logic [CTR_WIDTH-1:0] ON_TC  = CTR_WIDTH'(ON_CYCLES - 1);
    localparam logic [CTR_WIDTH-1:0] OFF_TC = CTR_WIDTH'(OFF_CYCLES - 1);

    state_t               state, state_nxt;
    logic [CTR_WIDTH-1:0] ctr, ctr_nxt;
    logic [CNT_WIDTH-1:0] rem, rem_nxt;
    logic [CNT_WIDTH-1:0] pend_cnt, pend_cnt_nxt;
    logic                 pend, pend_nxt;
    logic                 done_nxt;
    logic                 req;

    // A zero blink count is never a request, so rem can never be loaded with 0.
    assign req = io.pulse_in && (io.blink_cnt != '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            ctr          <= '0;
            rem          <= '0;
            pend         <= 1'b0;
            pend_cnt     <= '0;
            io.led_out_n <= 1'b1;
            io.busy      <= 1'b0;
            io.done      <= 1'b0;
        end else begin
            state        <= state_nxt;
            ctr          <= ctr_nxt;
            rem          <= rem_nxt;
            pend         <= pend_nxt;
            pend_cnt     <= pend_cnt_nxt;
            io.led_out_n <= (state_nxt != ON);
            io.busy      <= (state_nxt != IDLE);
            io.done      <= done_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        ctr_nxt      = ctr + CTR_WIDTH'(1);
        rem_nxt      = rem;
        pend_nxt     = pend;
        pend_cnt_nxt = pend_cnt;
        done_nxt     = 1'b0;

        if (state != IDLE && req && !pend) begin
            pend_nxt     = 1'b1;
            pend_cnt_nxt = io.blink_cnt;
        end

        case (state)
            IDLE: begin
                ctr_nxt = '0;
                if (req) begin
                    rem_nxt   = io.blink_cnt;
                    state_nxt = ON;
                end
            end
            ON: begin
                if (ctr == ON_TC) begin
                    ctr_nxt = '0;
                    if (rem > CNT_WIDTH'(1)) begin
                        rem_nxt   = rem - CNT_WIDTH'(1);
                        state_nxt = OFF;
                    end else begin
                        done_nxt = 1'b1;
                        if (pend) begin
                            rem_nxt   = pend_cnt;
                            pend_nxt  = 1'b0;
                            state_nxt = GAP;
                        end else if (req) begin
                            // Request landing on the final ON cycle goes straight
                            // into the gap instead of sitting in the queue.
                            rem_nxt   = io.blink_cnt;
                            pend_nxt  = 1'b0;
                            state_nxt = GAP;
                        end else begin
                            state_nxt = IDLE;
                        end
                    end
                end
            end
            OFF, GAP: begin
                if (ctr == OFF_TC) begin
                    ctr_nxt   = '0;
                    state_nxt = ON;
                end
            end
            default: begin
                ctr_nxt   = '0;
                state_nxt = IDLE;
            end
        endcase
    end
endmodule

// File: tb/tb_gen_led_signal.sv
// Directed bench for gen_led_signal with ON_CYCLES=3, OFF_CYCLES=2.
module tb_gen_led_signal;
    localparam int CTR_W  = 4;
    localparam int ON_C   = 3;
    localparam int OFF_C  = 2;
    localparam int CNT_W  = 4;

    logic clk    = 1'b0;
    logic rst    = 1'b0;
    logic clk_en = 1'b0;
    int   errors = 0;
    int   checks = 0;

    gen_led_signal_if #(.CNT_WIDTH(CNT_W)) io ();

    gen_led_signal #(
        .CTR_WIDTH (CTR_W),
        .ON_CYCLES (ON_C),
        .OFF_CYCLES(OFF_C),
        .CNT_WIDTH (CNT_W)
    ) dut (
        .clk(clk),
        .rst(rst),
        .io (io)
    );

    always #5 if (clk_en) clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic el, input logic eb, input logic ed);
        check({tag, " led_out_n"}, io.led_out_n, el);
        check({tag, " busy"},      io.busy,      eb);
        check({tag, " done"},      io.done,      ed);
    endtask

    // mode 0: two-blink burst, 1: zero count, 2: queued burst, 3: queue full
    task automatic scenario(input int mode);
        logic el, eb, ed;
        bit   q;
        q = (mode >= 2);
        for (int c = 1; c <= 32; c++) begin
            tick();
            if (mode == 1) begin
                el = 1'b1; eb = 1'b0; ed = 1'b0;
            end else begin
                el = !((c >= 11 && c <= 13) || (c >= 16 && c <= 18) || (q && c >= 21 && c <= 23));
                eb = (c >= 11 && c <= 18) || (q && c >= 19 && c <= 23);
                ed = (c == 19) || (q && c == 24);
            end
            check_all($sformatf("m%0d c%0d", mode, c), el, eb, ed);
            io.pulse_in  = 1'b0;
            io.blink_cnt = '0;
            if (c == 10) begin
                io.pulse_in  = 1'b1;
                io.blink_cnt = (mode == 1) ? 4'd0 : 4'd2;
            end
            if (c == 12 && q) begin
                io.pulse_in  = 1'b1;
                io.blink_cnt = 4'd1;
            end
            if (c == 13 && mode == 3) begin
                io.pulse_in  = 1'b1;
                io.blink_cnt = 4'd5;
            end
        end
    endtask

    initial begin
        io.pulse_in  = 1'b0;
        io.blink_cnt = '0;

        // Reset with no clock running
        #1 rst = 1'b1;
        #1 check_all("reset noclk", 1'b1, 1'b0, 1'b0);

        clk_en = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        for (int c = 0; c < 4; c++) begin
            tick();
            check_all($sformatf("post-reset c%0d", c), 1'b1, 1'b0, 1'b0);
        end

        scenario(0);
        scenario(1);
        scenario(2);
        scenario(3);

        // Reset mid-burst
        for (int c = 1; c <= 13; c++) begin
            tick();
            check_all($sformatf("rstmid c%0d", c),
                      !(c >= 11 && c <= 13), (c >= 11), 1'b0);
            io.pulse_in  = (c == 10);
            io.blink_cnt = (c == 10) ? 4'd2 : 4'd0;
        end
        #2 rst = 1'b1;
        #1 check_all("rstmid async", 1'b1, 1'b0, 1'b0);
        tick();
        check_all("rstmid held", 1'b1, 1'b0, 1'b0);
        rst = 1'b0;
        for (int c = 1; c <= 12; c++) begin
            tick();
            check_all($sformatf("fresh c%0d", c),
                      !(c >= 6 && c <= 8), (c >= 6 && c <= 8), (c == 9));
            io.pulse_in  = (c == 5);
            io.blink_cnt = (c == 5) ? 4'd1 : 4'd0;
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/gen_led_signal.md
# gen_led_signal

Pulse-to-indicator driver: converts a one-cycle event pulse, such as a debounced key event, into a multi-cycle, human-visible, active-low indicator burst. Each accepted pulse produces `N` blinks of programmable on/off length. One further request can be queued while a burst is running. The block sits on the front-panel side of the design, next to the key pulse generators, and drives LEDs or beepers directly.

## Interface
Parameters:
- `CTR_WIDTH`, default 22: width of the on/off period counter.
- `ON_CYCLES`, default 2500000: indicator-active cycles per blink. Legal range 1..2^CTR_WIDTH-1.
- `OFF_CYCLES`, default 2500000: indicator-inactive cycles between blinks. Legal range 1..2^CTR_WIDTH-1.
- `CNT_WIDTH`, default 4: width of the blink-count input.

Ports:
- `clk`, input, 1: the single clock.
- `rst`, input, 1: asynchronous, active-high reset.
- `pulse_in`, input, 1: one-cycle burst request. Sampled every rising edge.
- `blink_cnt`, input, CNT_WIDTH: number of blinks. Sampled only in the cycle `pulse_in` is high.
- `led_out_n`, output reg, 1: indicator, active low.
- `busy`, output reg, 1: a burst (or its queued successor) is in progress.
- `done`, output reg, 1: one-cycle pulse at the end of each burst.

## Operation
- States: `IDLE`, `ON`, `OFF`, `GAP`.
- Registers: period counter `ctr` (CTR_WIDTH bits), remaining-blink counter `rem` (CNT_WIDTH bits), `pend` flag, `pend_cnt` (CNT_WIDTH bits).
- **IDLE**
  - `pulse_in=1` with `blink_cnt!=0`: load `rem=blink_cnt`, clear `ctr`, go to ON.
  - `pulse_in=1` with `blink_cnt==0`: ignored. No `busy`, no `done`.
- **ON**
  - `led_out_n=0`; `ctr` counts 0..ON_CYCLES-1.
  - At terminal count with `rem>1`: decrement `rem`, clear `ctr`, go to OFF.
  - At terminal count with `rem==1`, `pend=0`: go to IDLE and assert `done`.
  - At terminal count with `rem==1`, `pend=1`: assert `done`, load `rem=pend_cnt`, clear `pend`, go to GAP.
- **OFF / GAP**
  - `led_out_n=1`; `ctr` counts 0..OFF_CYCLES-1, then go to ON.
  - GAP differs from OFF only in being entered between bursts.
- **Request while busy**
  - `pulse_in=1` with `blink_cnt!=0` and `pend=0`: set `pend`, latch `pend_cnt`.
  - `pend` already set, or `blink_cnt==0`: request dropped. Queue depth is exactly one.
- **Pulse in the cycle `done` is high:** the FSM is already in IDLE (or GAP), so the normal IDLE/busy rules apply.
- **Arithmetic:** counters compare against parameter constants truncated to CTR_WIDTH. `rem` never wraps: a zero count is never loaded.

## Timing
- Reset values, applied asynchronously with no clock needed:
  - outputs: `led_out_n=1`, `busy=0`, `done=0`
  - internal: `pend=0`, `rem=0`, `ctr=0`, state IDLE.
- All outputs are registered.
- A pulse sampled at edge T gives `led_out_n=0` and `busy=1` from edge T+1.
- Each ON phase lasts exactly ON_CYCLES cycles; each OFF or GAP phase lasts exactly OFF_CYCLES cycles.
- `done` is high for exactly one cycle: the first cycle after the final ON phase, when `led_out_n` has returned to 1.
- `busy` falls in the same cycle `done` rises, unless a queued burst follows. In that case `busy` stays high through GAP.
- Latency from accepted pulse to burst end: `N*ON_CYCLES + (N-1)*OFF_CYCLES` cycles, then `done`.
- `rst` asserted mid-burst: `led_out_n` returns to 1 immediately and the queued request is discarded. After `rst` deasserts, nothing restarts until a new pulse arrives.

## Test plan
Bench parameters: `CTR_WIDTH=4`, `ON_CYCLES=3`, `OFF_CYCLES=2`.

- **Reset values:** assert `rst` with no clock running → `led_out_n=1`, `busy=0`, `done=0` immediately. After release with no input, all three hold.
- **Two-blink burst:** `pulse_in` at cycle 10 with `blink_cnt=2` →
  - `led_out_n` low cycles 11-13, high 14-15, low 16-18
  - `busy` high 11-18
  - `done` high only at 19, with `led_out_n=1` there.
- **Zero count ignored:** `pulse_in` with `blink_cnt=0` → no change on any output for 20 cycles.
- **Queued burst:** start as in the two-blink case, then `pulse_in` at cycle 12 with `blink_cnt=1` →
  - first `done` at 19; `led_out_n` high 19-20 (GAP), low 21-23
  - second `done` at 24
  - `busy` high continuously 11-23.
- **Queue full:** with a request already queued (queued-burst case), a further pulse at cycle 13 with `blink_cnt=5` → dropped. Only one extra blink occurs and the sequence is identical to the queued-burst case.
- **Reset mid-burst:** `rst` asserted at cycle 13 of the two-blink case → `led_out_n=1` and `busy=0` immediately, no `done`. A fresh pulse afterwards starts a clean burst.
